// File: rtl/screen_controller_if.sv
// screen_controller_if: raster, pointer, control and pixel signals of the screen controller
interface screen_controller_if;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        new_frame_in;
  logic [10:0] cursor_x_in;
  logic [9:0]  cursor_y_in;
  logic        cursor_valid_in;
  logic        start_btn_in;
  logic        game_over_in;
  logic [23:0] start_pixel_in;
  logic [23:0] game_pixel_in;
  logic [23:0] pixel_out;
  logic [1:0]  state_out;
  logic [1:0]  countdown_out;
  logic        game_active_out;
  logic        hover_out;
  modport master (
    output hcount_in, vcount_in, new_frame_in, cursor_x_in, cursor_y_in, cursor_valid_in,
           start_btn_in, game_over_in, start_pixel_in, game_pixel_in,
    input  pixel_out, state_out, countdown_out, game_active_out, hover_out
  );
  modport slave (
    input  hcount_in, vcount_in, new_frame_in, cursor_x_in, cursor_y_in, cursor_valid_in,
           start_btn_in, game_over_in, start_pixel_in, game_pixel_in,
    output pixel_out, state_out, countdown_out, game_active_out, hover_out
  );
endinterface

// File: rtl/screen_controller.sv
// screen_controller: idle/countdown/play/over screen sequencing with hover-dwell start and pixel mux
module screen_controller #(
  parameter int BTN_X        = 300,
  parameter int BTN_Y        = 300,
  parameter int BTN_W        = 200,
  parameter int BTN_H        = 100,
  parameter int DWELL_FRAMES = 30,
  parameter int CD_FRAMES    = 60,
  parameter int CD_START     = 3,
  parameter int OVER_FRAMES  = 180
) (
  input logic clk_in,
  input logic rst_in,
  screen_controller_if.slave s
);
  localparam int FMAX = (CD_FRAMES > OVER_FRAMES) ? CD_FRAMES : OVER_FRAMES;
  localparam int DW   = $clog2(DWELL_FRAMES + 1);
  localparam int FW   = $clog2(FMAX + 1);
  localparam logic [11:0] X_LO = 12'(BTN_X);
  localparam logic [11:0] X_HI = 12'(BTN_X + BTN_W);
  localparam logic [10:0] Y_LO = 11'(BTN_Y);
  localparam logic [10:0] Y_HI = 11'(BTN_Y + BTN_H);
  typedef enum logic [1:0] {IDLE = 2'd0, COUNTDOWN = 2'd1, PLAY = 2'd2, OVER = 2'd3} state_t;
  state_t         r_state, w_state;
  logic [1:0]     r_cd, w_cd;
  logic [DW-1:0]  r_dwell, w_dwell;
  logic [FW-1:0]  r_frame, w_frame;
  logic           r_hover, w_hover;
  logic           r_prev;
  logic           r_active;
  logic [23:0]    r_pix, w_pix;
  logic           w_hit, w_pix_in, w_start;
  assign w_hit    = s.cursor_valid_in &&
                    {1'b0, s.cursor_x_in} >= X_LO && {1'b0, s.cursor_x_in} < X_HI &&
                    {1'b0, s.cursor_y_in} >= Y_LO && {1'b0, s.cursor_y_in} < Y_HI;
  assign w_pix_in = {1'b0, s.hcount_in} >= X_LO && {1'b0, s.hcount_in} < X_HI &&
                    {1'b0, s.vcount_in} >= Y_LO && {1'b0, s.vcount_in} < Y_HI;
  // r_prev starts high so a button held through reset is not seen as a press
  assign w_start  = s.start_btn_in && !r_prev;
  // next-state and next counter/flag values
  always_comb begin
    w_state = r_state;
    w_cd    = r_cd;
    w_dwell = r_dwell;
    w_frame = r_frame;
    w_hover = r_hover;
    case (r_state)
      IDLE: begin
        if (s.new_frame_in) begin
          w_hover = w_hit;
          w_dwell = !w_hit ? '0 : (r_dwell == DW'(DWELL_FRAMES)) ? r_dwell : r_dwell + 1'b1;
        end
        if (w_start || (s.new_frame_in && w_hit && r_dwell == DW'(DWELL_FRAMES - 1))) begin
          w_state = COUNTDOWN;
          w_cd    = 2'(CD_START);
          w_frame = '0;
          w_dwell = '0;
          w_hover = 1'b0;
        end
      end
      COUNTDOWN: begin
        if (s.new_frame_in) begin
          if (r_frame == FW'(CD_FRAMES - 1)) begin
            w_frame = '0;
            w_cd    = (r_cd > 2'd1) ? r_cd - 2'd1 : 2'd0;
            w_state = (r_cd > 2'd1) ? COUNTDOWN : PLAY;
          end else
            w_frame = r_frame + 1'b1;
        end
      end
      PLAY: begin
        if (s.game_over_in) begin
          w_state = OVER;
          w_frame = '0;
        end
      end
      OVER: begin
        if (s.new_frame_in) begin
          if (r_frame == FW'(OVER_FRAMES - 1)) begin
            w_state = IDLE;
            w_frame = '0;
            w_dwell = '0;
          end else
            w_frame = r_frame + 1'b1;
        end
      end
    endcase
  end
  // pixel select from the current screen
  always_comb begin
    w_pix = (r_state == IDLE) ? ((r_hover && w_pix_in) ? (s.start_pixel_in | 24'h404040) : s.start_pixel_in) :
            (r_state == OVER) ? {8'hFF, 1'b0, s.game_pixel_in[15:9], 1'b0, s.game_pixel_in[7:1]} :
            s.game_pixel_in;
  end
  // state, counters and registered outputs
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state  <= IDLE;
      r_cd     <= '0;
      r_dwell  <= '0;
      r_frame  <= '0;
      r_hover  <= 1'b0;
      r_prev   <= 1'b1;
      r_active <= 1'b0;
      r_pix    <= '0;
    end else begin
      r_state  <= w_state;
      r_cd     <= w_cd;
      r_dwell  <= w_dwell;
      r_frame  <= w_frame;
      r_hover  <= w_hover;
      r_prev   <= s.start_btn_in;
      r_active <= (w_state == PLAY);
      r_pix    <= w_pix;
    end
  end
  assign s.pixel_out       = r_pix;
  assign s.state_out       = r_state;
  assign s.countdown_out   = r_cd;
  assign s.game_active_out = r_active;
  assign s.hover_out       = r_hover;
endmodule
